// File: rtl/prio_arbiter8.sv
// Eight-requester arbiter: highest-index fixed priority or round-robin, with grant
// ownership, a maximum-hold timeout and a one-arbitration mask for the timed-out owner.
module prio_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       rr_en,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       grant_valid,
   output logic       timeout
);

   localparam int            CW        = $clog2(MAX_HOLD);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    grant_q, grant_d;
   logic [2:0]    grant_id_q, grant_id_d;
   logic          timeout_q, timeout_d;
   logic [7:0]    mask_q, mask_d;
   logic [2:0]    last_id_q, last_id_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;

   logic [7:0]    eff_req;
   logic          pick_found;
   logic [2:0]    pick_id;
   logic [2:0]    rr_idx;

   // Winner selection over the effective request; only consumed in IDLE.
   always_comb begin
      eff_req    = req & ~mask_q;
      pick_found = |eff_req;
      pick_id    = '0;
      rr_idx     = '0;
      if (!rr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (eff_req[i]) pick_id = 3'(i);
         end
      end else begin
         // Walk last_id-1, last_id-2, ... wrapping, ending on last_id itself.
         for (int i = 8; i >= 1; i--) begin
            rr_idx = last_id_q - 3'(i);
            if (eff_req[rr_idx]) pick_id = rr_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      timeout_d  = 1'b0;
      mask_d     = mask_q;
      last_id_d  = last_id_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         S_IDLE: begin
            mask_d = '0;
            if (pick_found) begin
               grant_d    = 8'b1 << pick_id;
               grant_id_d = pick_id;
               last_id_d  = pick_id;
               hold_cnt_d = '0;
               state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (!req[grant_id_q]) begin
               grant_d = '0;
               state_d = S_IDLE;
            end else if (hold_cnt_q == HOLD_LAST) begin
               grant_d   = '0;
               timeout_d = 1'b1;
               mask_d    = grant_q;
               state_d   = S_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         timeout_q  <= 1'b0;
         mask_q     <= '0;
         last_id_q  <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         timeout_q  <= timeout_d;
         mask_q     <= mask_d;
         last_id_q  <= last_id_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = |grant_q;
   assign timeout     = timeout_q;

endmodule

// File: doc/prio_arbiter8.md
# prio_arbiter8

Eight-requester arbiter for a single shared resource. Uses the same priority rule as the team's 8-to-3 priority encoder: the highest index wins, and the winner is reported as a 3-bit binary ID. On top of that rule it adds grant ownership, an optional round-robin rotation and a maximum-hold timeout, so one requester cannot starve the others. It sits between the requesting blocks and the resource's mux/select input, and drives that select directly from `grant_id`.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold a grant. Legal range is 2..256. The hold counter is `$clog2(MAX_HOLD)` bits wide.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 8: request vector. Bit n is requester n. A requester holds its bit high for as long as it wants the resource.
- `rr_en`, input, 1: 0 selects fixed priority; 1 selects round-robin. It is sampled only in IDLE.
- `grant`, output, 8: one-hot grant, registered.
- `grant_id`, output, 3: binary index of the owner, registered. Holds its last value when `grant_valid`=0.
- `grant_valid`, output, 1: high while any grant is active; equals `|grant`.
- `timeout`, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- The block has two states, IDLE and GRANT.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise, pick a winner, register `grant`/`grant_id`/`grant_valid`, clear `hold_cnt` and go to GRANT.
- Fixed-priority winner (`rr_en`=0): the highest set bit of the effective request, with the encoder ordering 7 > 6 > … > 0.
- Round-robin winner (`rr_en`=1): search the effective request in the order last_id-1, last_id-2, … (wrapping 0→7), ending with last_id itself.
  - `last_id` is the ID of the most recent grant.
  - After reset `last_id`=0, so the first round-robin order is 7..0, identical to fixed priority.
- Effective request is `req & ~mask`.
  - `mask` is one-hot for the requester that just timed out, and zero otherwise.
  - `mask` applies to exactly one IDLE cycle, then clears.
  - If `req & ~mask` is 0 but `req`≠0 (only the masked requester is asking), there is no grant that cycle; `mask` still clears.
- GRANT:
  - Each cycle, `hold_cnt` increments.
  - If `req[grant_id]`=0 (voluntary release): next cycle `grant`=0, `grant_valid`=0, state IDLE, `last_id` keeps the owner ID, `timeout`=0.
  - Otherwise, if `hold_cnt`==MAX_HOLD-1 (forced release): next cycle `grant`=0, `grant_valid`=0, `timeout`=1, `mask` is set to the owner's bit, state IDLE.
  - Otherwise the grant is held. Changes to other `req` bits are ignored while in GRANT.
- Release takes priority: if the release and the hold limit fall in the same cycle, it is a voluntary release with no `timeout`.
- Ownership never transfers directly. There is always at least one IDLE cycle with `grant_valid`=0 between owners, so the resource select is never glitched.
- Reset (any cycle, including mid-grant): next edge gives state IDLE, `grant`=0, `grant_id`=0, `grant_valid`=0, `timeout`=0, `mask`=0, `last_id`=0, `hold_cnt`=0. Reset overrides every other transition.

## Timing
- Request-to-grant latency is one cycle. A `req` sampled at edge k in IDLE produces a grant visible after edge k+1.
- Maximum hold is MAX_HOLD cycles with `grant_valid`=1, counted from the first grant cycle.
- Release-to-regrant:
  - Voluntary release: `req` drops at edge k, `grant_valid` goes low after k+1, and the next grant appears after k+2 at the earliest.
  - Timeout: same spacing; `timeout` is high in the same cycle that `grant_valid` goes low.
- `grant` is always one-hot or zero; `grant_id` always matches the set bit of `grant`.
- No combinational path from `req` to any output.

## Test plan
- Reset mid-grant: hold `req`=8'h80, assert `rst` for 1 cycle while `grant`=8'h80 → next cycle all outputs are 0. Two cycles after `rst` falls, `grant`=8'h80 and `grant_id`=7.
- Fixed priority: `rr_en`=0, `req`=8'h2C → `grant`=8'h20, `grant_id`=5. Drop bit 5 → one cycle with `grant_valid`=0, then `grant`=8'h08, `grant_id`=3.
- Round-robin: `rr_en`=1, `req`=8'hFF, every owner releases after one grant cycle and re-requests → grant IDs 7,6,5,4,3,2,1,0,7 with exactly one idle cycle between each.
- Timeout, MAX_HOLD=4: `req`=8'h81 held high continuously → `grant_id`=7 for 4 cycles, then `timeout`=1 and `grant_valid`=0 for 1 cycle. The next grant is `grant_id`=0, not 7, even in fixed mode.
- Lone masked requester, MAX_HOLD=4: only `req`=8'h04 held high → 4 grant cycles, then the timeout cycle, then one IDLE cycle with no grant (mask), then `grant_id`=2 again.
- Release on the limit cycle: MAX_HOLD=4, owner drops `req` in its 4th grant cycle → `grant_valid` falls and `timeout` stays 0; the next arbitration is unmasked.
